spi_master: RTL
===============

# spi_master

Synchronous SPI master that serialises a DATA_WIDTH word onto MOSI while capturing MISO, in all four CPOL/CPHA modes. It is the upstream partner of `spi_slave`: it generates `sclk`, `cs_n` and `mosi` from a system clock and delivers the received word to the host logic with a start/done handshake. Host logic (register file or DMA) sits above it.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer (at least 2).
- `MSB_FIRST`, default 1: 1 shifts bit DATA_WIDTH-1 first; 0 shifts bit 0 first. Applies to both MOSI and MISO.
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period (at least 1).
- `clk` in 1: system clock. All logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transfer. Sampled only when `busy`=0.
- `tx_data` in DATA_WIDTH: word to send. Latched on accepted `start`.
- `cpol` in 1: clock polarity. Latched on accepted `start`.
- `cpha` in 1: clock phase. Latched on accepted `start`.
- `busy` out 1: high from the cycle after acceptance until the `done` cycle.
- `done` out 1: one-cycle pulse. `rx_data` is valid from this cycle.
- `rx_data` out DATA_WIDTH: last received word. Held until the next `done`.
- `sclk` out 1: SPI clock, registered.
- `cs_n` out 1: active-low chip select, registered.
- `mosi` out 1: serial data out, registered.
- `miso` in 1: serial data in, sampled on `clk`.

## Operation
- States:
  - IDLE: `cs_n`=1, `sclk` <= `cpol` each cycle, `mosi` holds its last value.
  - SETUP: `cs_n`=0. Lasts CLK_DIV cycles.
  - SHIFT: 2×DATA_WIDTH SCLK edges, one every CLK_DIV cycles.
  - HOLD: `cs_n`=0, `sclk` idle. Lasts CLK_DIV cycles.
  - After HOLD: return to IDLE.
- Transitions:
  - IDLE→SETUP on `start`=1: latch `tx_data`, `cpol`, `cpha` into shadow registers.
  - SETUP→SHIFT after CLK_DIV cycles.
  - SHIFT→HOLD after edge 2×DATA_WIDTH.
  - HOLD→IDLE after CLK_DIV cycles.
- On entering SETUP with cpha=0, `mosi` is driven with the first bit in the same cycle `cs_n` falls. With cpha=1, `mosi` is unchanged until edge 1.
- Edges are numbered 1..2×DATA_WIDTH. Odd edges are leading (sclk leaves `cpol`); even edges are trailing.
- cpha=0: leading edge samples `miso`; trailing edge drives the next bit onto `mosi`, except after the last bit.
- cpha=1: leading edge drives the next bit onto `mosi`; trailing edge samples `miso`.
- "Sample" means the `miso` value present at the `clk` edge that toggles `sclk`. That bit is shifted into the receive register in the direction set by MSB_FIRST.
- After edge 2×DATA_WIDTH, `sclk` equals the latched `cpol`.
- At the HOLD→IDLE cycle: `cs_n`=1, `busy`=0, `done`=1, and `rx_data` is updated with the shift register.
- `start` while `busy`=1 is ignored. Changes to `cpol`, `cpha` or `tx_data` mid-transfer have no effect.
- Back-to-back transfers: `start` is accepted in the `done` cycle. `cs_n` is then high for exactly one cycle.
- `rst` mid-transfer, effective immediately:
  - `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
  - State goes to IDLE. No `done` pulse is produced for the aborted transfer.
  - After release, `sclk` follows `cpol` from the next cycle.

## Timing
- Start accepted at cycle 0 (rising edge with `start`=1, `busy`=0).
- Cycle 1: `cs_n`=0, `busy`=1.
- Edge k appears at cycle 1 + CLK_DIV×k, for k = 1..2×DATA_WIDTH.
- `cs_n`=1 and `done`=1 at cycle 1 + CLK_DIV×(2×DATA_WIDTH+2). For the defaults this is cycle 73.
- SCLK frequency is f_clk/(2×CLK_DIV).
- The half-period counter runs from 0 to CLK_DIV-1 and wraps. The edge counter needs ceil(log2(2×DATA_WIDTH+1)) bits.
- Reset values: `sclk`=0, `cs_n`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.

## Structure
- `spi_pkg` holds:
  - the state enum: IDLE, SETUP, SHIFT, HOLD;
  - the SPI mode constants MODE0..MODE3 as {cpol,cpha}.
- It is shared with `spi_slave` and the benches.
- One sub-module, `spi_clk_gen`:
  - inputs: enable, CLK_DIV counter;
  - outputs: one-cycle `half_tick` strobe and `edge_idx` count;
  - reset to 0 whenever enable is low.
- The top level holds the FSM and the shift registers.

## Test plan
- Mode 0 loopback to `spi_slave` (slave `tx_data`=0xA5), master sends 0x3C → slave `rx_data`=0x3C with `rx_valid`; master `rx_data`=0xA5 on `done`; `done` at cycle 73.
- Modes 1, 2 and 3 with pairs (0x55/0xF0), (0x99/0x12), (0x42/0x77) → both directions match. `sclk` idle level equals `cpol` before and after each transfer.
- MSB_FIRST=0, `tx_data`=0x01 → `mosi` is 1 on the first bit only; `miso` tied to the pattern 1,0,0,0,0,0,0,0 → `rx_data`=0x01.
- `start` held high continuously for 3 transfers → 3 `done` pulses; `cs_n` high for exactly 1 cycle between them. A `start` pulse during `busy` is ignored and does not change the shadow `tx_data`.
- `rst` asserted at edge 5 of a transfer → outputs immediately at reset values, no `done`. The next transfer of 0xC3 completes correctly.
- CLK_DIV=1 → `sclk` toggles every cycle; mode 0 loopback of 0x81 passes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and {cpol,cpha} mode encodings.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timebase: one-cycle strobe every CLK_DIV clocks plus a count of strobes
// seen since enable rose. Everything clears while enable is low.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned EDGE_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic              o_half_tick,
  output logic [EDGE_W-1:0] o_edge_idx
);

  localparam int unsigned      CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge_idx;

  assign o_half_tick = i_en && (r_cnt == CNT_MAX);
  assign o_edge_idx  = r_edge_idx;

  // Half-period counter wraps at CLK_DIV-1; each wrap bumps the edge index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_edge_idx <= '0;
    end else if (!i_en) begin
      r_cnt      <= '0;
      r_edge_idx <= '0;
    end else if (o_half_tick) begin
      r_cnt      <= '0;
      r_edge_idx <= r_edge_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises tx_data on mosi while capturing miso, all four modes,
// with a start/done handshake toward host logic.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned       EDGES     = 2 * DATA_WIDTH;
  localparam int unsigned       EDGE_W    = $clog2(EDGES + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES);
  localparam logic [EDGE_W-1:0] LAST_M1   = EDGE_W'(EDGES - 1);

  spi_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_en;
  logic                  w_tick;
  logic [EDGE_W-1:0]     w_edge_idx;
  logic                  w_leading;
  logic                  w_tx_head;
  logic [DATA_WIDTH-1:0] w_tx_shift;
  logic                  w_in_head;
  logic [DATA_WIDTH-1:0] w_in_shift;
  logic [DATA_WIDTH-1:0] w_rx_shift;

  assign w_en      = (r_state != IDLE);
  // sclk still at its idle level means the next toggle is a leading edge.
  assign w_leading = (r_sclk == r_cpol);

  assign w_tx_head  = (MSB_FIRST != 0) ? r_tx[DATA_WIDTH-1] : r_tx[0];
  assign w_tx_shift = (MSB_FIRST != 0) ? {r_tx[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, r_tx[DATA_WIDTH-1:1]};
  assign w_in_head  = (MSB_FIRST != 0) ? tx_data[DATA_WIDTH-1] : tx_data[0];
  assign w_in_shift = (MSB_FIRST != 0) ? {tx_data[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, tx_data[DATA_WIDTH-1:1]};
  assign w_rx_shift = (MSB_FIRST != 0) ? {r_rx[DATA_WIDTH-2:0], miso}
                                       : {miso, r_rx[DATA_WIDTH-1:1]};

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .EDGE_W  (EDGE_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_en),
    .o_half_tick (w_tick),
    .o_edge_idx  (w_edge_idx)
  );

  // Transfer FSM. Strobe n (edge index n-1 before increment) performs SCLK edge n
  // for n = 1..2*DATA_WIDTH; strobe 2*DATA_WIDTH+1 closes SHIFT, the next ends HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= cpol;
          r_cs_n <= 1'b1;
          if (start) begin
            r_state <= SETUP;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_rx    <= '0;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            if (!cpha) begin
              r_mosi <= w_in_head;
              r_tx   <= w_in_shift;
            end else begin
              r_tx <= tx_data;
            end
          end
        end
        SETUP, SHIFT: begin
          if (w_tick) begin
            if (w_edge_idx == LAST_EDGE) begin
              r_state <= HOLD;
            end else begin
              r_state <= SHIFT;
              r_sclk  <= ~r_sclk;
              if (w_leading) begin
                if (!r_cpha) begin
                  r_rx <= w_rx_shift;
                end else begin
                  r_mosi <= w_tx_head;
                  r_tx   <= w_tx_shift;
                end
              end else begin
                if (r_cpha) begin
                  r_rx <= w_rx_shift;
                end else if (w_edge_idx != LAST_M1) begin
                  r_mosi <= w_tx_head;
                  r_tx   <= w_tx_shift;
                end
              end
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state   <= IDLE;
            r_sclk    <= r_cpol;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule
